// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int HOLD_W     = 4;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
        return (cnt == {HOLD_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection: round-robin with a bounded hold limit
// (lock inputs override the limit when RAM_ARB_LOCK_EN is defined in the top).
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  arb_state_t        i_state,
    input  logic              i_last,
    input  logic [HOLD_W-1:0] i_hold_cnt,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    output logic              o_gnt0,
    output logic              o_gnt1
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    // >= rather than == so a count that ran past the limit under lock still yields.
    logic w_hold_hit;
    assign w_hold_hit = (i_hold_cnt >= HOLD_LIM);

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        unique case (i_state)
            OWN0: begin
                if (i_req0 && !(i_req1 && w_hold_hit && !i_lock0)) o_gnt0 = 1'b1;
                else if (i_req1)                                  o_gnt1 = 1'b1;
            end
            OWN1: begin
                if (i_req1 && !(i_req0 && w_hold_hit && !i_lock1)) o_gnt1 = 1'b1;
                else if (i_req0)                                  o_gnt0 = 1'b1;
            end
            default: begin
                if (i_req0 && i_req1) begin
                    o_gnt0 = i_last;
                    o_gnt1 = !i_last;
                end else begin
                    o_gnt0 = i_req0;
                    o_gnt1 = i_req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port RAM with 1-cycle read latency.
// Optional RAM_ARB_LOCK_EN adds lock0/lock1 to let an owner exceed the hold limit.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
`ifdef RAM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);

    arb_state_t        r_state;
    logic              r_last;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [ADDR_W-1:0] r_addr;

    logic w_lock0;
    logic w_lock1;
    logic w_pick0;
    logic w_pick1;

`ifdef RAM_ARB_LOCK_EN
    assign w_lock0 = lock0;
    assign w_lock1 = lock1;
`else
    assign w_lock0 = 1'b0;
    assign w_lock1 = 1'b0;
`endif

    ram_arb_pick #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .i_state    (r_state),
        .i_last     (r_last),
        .i_hold_cnt (r_hold_cnt),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_lock0    (w_lock0),
        .i_lock1    (w_lock1),
        .o_gnt0     (w_pick0),
        .o_gnt1     (w_pick1)
    );

    // Grants are forced off while reset is held, independent of the clock.
    assign gnt0 = w_pick0 & rst_n;
    assign gnt1 = w_pick1 & rst_n;

    assign ram_w_en   = (gnt0 & we0) | (gnt1 & we1);
    assign ram_addr   = gnt0 ? addr0 : (gnt1 ? addr1 : r_addr);
    assign ram_w_data = gnt1 ? wdata1 : wdata0;
    assign rdata      = ram_r_data;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_rvalid0 <= gnt0 & ~we0;
            r_rvalid1 <= gnt1 & ~we1;
            if (gnt0) begin
                r_state    <= OWN0;
                r_last     <= 1'b0;
                r_hold_cnt <= (r_state == OWN0) ? hold_inc(r_hold_cnt) : '0;
            end else if (gnt1) begin
                r_state    <= OWN1;
                r_last     <= 1'b1;
                r_hold_cnt <= (r_state == OWN1) ? hold_inc(r_hold_cnt) : '0;
            end else begin
                r_state    <= IDLE;
                r_hold_cnt <= '0;
            end
        end
    end

    // Address is datapath only; it just parks the RAM on the last granted address.
    always_ff @(posedge clk) begin
        if (gnt0 || gnt1) r_addr <= ram_addr;
    end

endmodule
